alu_pipe: RTL

//  Two-stage pipelined successor of the combinational ALU, parametrised in data width.
//  - Accepts operand/opcode beats on a valid/ready input port; returns result plus flags on a valid/ready output port.
//  - Full-throughput backpressure: one op per cycle.
//  - Sits between the operand register file/UART front-end and the result sink.

---
 rtl/alu_pipe_if.sv | 32 +++
 rtl/alu_pipe.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/alu_pipe_if.sv
// Operand/opcode request and result/flags response channels of alu_pipe.
// The slave modport is the ALU side; the master modport is the client side.
interface alu_pipe_if #(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6
);
    logic [SIZEDATA-1:0] DATOA;
    logic [SIZEDATA-1:0] DATOB;
    logic [SIZEOP-1:0]   OPCODE;
    logic                IN_VALID;
    logic                IN_READY;
    logic [SIZEDATA-1:0] RESULT;
    logic                CARRY;
    logic                ZERO;
    logic                NEGATIVE;
    logic                OVERFLOW;
    logic                ERR;
    logic                OUT_VALID;
    logic                OUT_READY;

    modport master (
        output DATOA, DATOB, OPCODE, IN_VALID, OUT_READY,
        input  IN_READY, RESULT, CARRY, ZERO, NEGATIVE,
        input  OVERFLOW, ERR, OUT_VALID
    );

    modport slave (
        input  DATOA, DATOB, OPCODE, IN_VALID, OUT_READY,
        output IN_READY, RESULT, CARRY, ZERO, NEGATIVE,
        output OVERFLOW, ERR, OUT_VALID
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready flow control on both sides.
// Define ALU_MUL_EN to add the MULTU opcode.
module alu_pipe #(
    parameter int SIZEDATA = 8,
    parameter int SIZEOP   = 6
) (
    input logic       CLK,
    input logic       RESET_N,
    alu_pipe_if.slave bus
);
    localparam logic [SIZEOP-1:0] OP_ADD = SIZEOP'(6'b100000);
    localparam logic [SIZEOP-1:0] OP_SUB = SIZEOP'(6'b100010);
    localparam logic [SIZEOP-1:0] OP_AND = SIZEOP'(6'b100100);
    localparam logic [SIZEOP-1:0] OP_OR  = SIZEOP'(6'b100101);
    localparam logic [SIZEOP-1:0] OP_XOR = SIZEOP'(6'b100110);
    localparam logic [SIZEOP-1:0] OP_NOR = SIZEOP'(6'b100111);
    localparam logic [SIZEOP-1:0] OP_SLL = SIZEOP'(6'b000000);
    localparam logic [SIZEOP-1:0] OP_SRL = SIZEOP'(6'b000010);
    localparam logic [SIZEOP-1:0] OP_SRA = SIZEOP'(6'b000011);
    localparam logic [SIZEOP-1:0] OP_SLT = SIZEOP'(6'b101010);
`ifdef ALU_MUL_EN
    localparam logic [SIZEOP-1:0] OP_MUL = SIZEOP'(6'b011001);
`endif
    localparam logic [SIZEDATA-1:0] WIDTH_V = SIZEDATA'(SIZEDATA);
    localparam int MSB = SIZEDATA - 1;

    logic                s1_valid;
    logic [SIZEDATA-1:0] s1_a;
    logic [SIZEDATA-1:0] s1_b;
    logic [SIZEOP-1:0]   s1_op;
    logic                s1_adv;
    logic                s2_adv;

    logic [SIZEDATA-1:0] s2_res;
    logic                s2_carry;
    logic                s2_zero;
    logic                s2_neg;
    logic                s2_ovf;
    logic                s2_err;
    logic                s2_valid;

    assign s2_adv       = !s2_valid || bus.OUT_READY;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.IN_READY = s1_adv;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.IN_VALID;
            if (bus.IN_VALID) begin
                s1_a  <= bus.DATOA;
                s1_b  <= bus.DATOB;
                s1_op <= bus.OPCODE;
            end
        end
    end

    logic [SIZEDATA:0]   sum;
    logic [SIZEDATA:0]   dif;
    logic [SIZEDATA-1:0] sra;
    logic                big_shift;
`ifdef ALU_MUL_EN
    logic [2*SIZEDATA-1:0] prod;
    assign prod = {{SIZEDATA{1'b0}}, s1_a}
                * {{SIZEDATA{1'b0}}, s1_b};
`endif

    assign sum       = {1'b0, s1_a} + {1'b0, s1_b};
    assign dif       = {1'b0, s1_a} - {1'b0, s1_b};
    assign sra       = $signed(s1_a) >>> s1_b;
    assign big_shift = s1_b >= WIDTH_V;

    logic [SIZEDATA-1:0] res;
    logic                carry;
    logic                ovf;
    logic                err;

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        err   = 1'b0;
        unique case (s1_op)
            OP_ADD: begin
                res   = sum[SIZEDATA-1:0];
                carry = sum[SIZEDATA];
                ovf   = (s1_a[MSB] == s1_b[MSB])
                     && (res[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                res   = dif[SIZEDATA-1:0];
                carry = dif[SIZEDATA];
                ovf   = (s1_a[MSB] != s1_b[MSB])
                     && (res[MSB] != s1_a[MSB]);
            end
            OP_AND: res = s1_a & s1_b;
            OP_OR:  res = s1_a | s1_b;
            OP_XOR: res = s1_a ^ s1_b;
            OP_NOR: res = ~(s1_a | s1_b);
            OP_SLL: res = big_shift ? '0 : s1_a << s1_b;
            OP_SRL: res = big_shift ? '0 : s1_a >> s1_b;
            OP_SRA: res = big_shift ? {SIZEDATA{s1_a[MSB]}} : sra;
            OP_SLT: res = {{(SIZEDATA-1){1'b0}},
                           $signed(s1_a) < $signed(s1_b)};
`ifdef ALU_MUL_EN
            OP_MUL: begin
                res   = prod[SIZEDATA-1:0];
                carry = |prod[2*SIZEDATA-1:SIZEDATA];
            end
`endif
            default: err = 1'b1;
        endcase
    end

    // Output stage holds its beat until the sink takes it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_carry <= 1'b0;
            s2_zero  <= 1'b0;
            s2_neg   <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_err   <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_res   <= res;
                s2_carry <= carry;
                s2_zero  <= (res == '0);
                s2_neg   <= res[MSB];
                s2_ovf   <= ovf;
                s2_err   <= err;
            end
        end
    end

    assign bus.RESULT    = s2_res;
    assign bus.CARRY     = s2_carry;
    assign bus.ZERO      = s2_zero;
    assign bus.NEGATIVE  = s2_neg;
    assign bus.OVERFLOW  = s2_ovf;
    assign bus.ERR       = s2_err;
    assign bus.OUT_VALID = s2_valid;
endmodule
